// File: rtl/conv3d_wfetch.sv
// ============================================================================
// conv3d_wfetch : burst weight fetcher, memory -> weight buffer
// Revision      : 1.0
// ============================================================================
`default_nettype none

module conv3d_wfetch #(
  parameter int AW       = 30,
  parameter int DW       = 256,
  parameter int MAXBURST = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_prefetch,
  input  logic [AW-1:0] cfg_waddr,
  input  logic [7:0]    cfg_length_w,
  output logic          rd_read,
  output logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_burstcount,
  input  logic          rd_waitrequest,
  input  logic          rd_readdatavalid,
  input  logic [DW-1:0] rd_readdata,
  output logic          wbuf_we,
  output logic [7:0]    wbuf_waddr,
  output logic [DW-1:0] wbuf_wdata,
  output logic          wfetch_busy,
  output logic          wfetch_done
);

  localparam int       c_BYTES = DW / 8;
  localparam logic [8:0] c_MAXB = 9'(MAXBURST);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DATA = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [AW-1:0] r_addr;
  logic [8:0]    r_remaining;
  logic [8:0]    r_idx;
  logic [7:0]    r_burst_left;
  logic [7:0]    r_cur_bc;
  logic          r_we;
  logic [7:0]    r_waddr;
  logic [DW-1:0] r_wdata;

  logic [7:0]    w_bc;
  logic [AW-1:0] w_step;
  logic          w_last_word;

  // Burst size is the smaller of what is left and the burst cap.
  assign w_bc        = (r_remaining > c_MAXB) ? 8'(MAXBURST) : r_remaining[7:0];
  assign w_step      = AW'(r_cur_bc) * AW'(c_BYTES);
  assign w_last_word = rd_readdatavalid && (r_burst_left == 8'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_prefetch) begin
          w_next = (cfg_length_w != 8'd0) ? S_REQ : S_DONE;
        end
      end
      S_REQ: begin
        if (!rd_waitrequest) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_last_word) begin
          w_next = (r_remaining != 9'd0) ? S_REQ : S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_idx        <= '0;
      r_burst_left <= '0;
      r_cur_bc     <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_prefetch) begin
            r_addr      <= cfg_waddr;
            r_remaining <= {1'b0, cfg_length_w};
            r_idx       <= '0;
          end
        end
        S_REQ: begin
          if (!rd_waitrequest) begin
            r_remaining  <= r_remaining - {1'b0, w_bc};
            r_burst_left <= w_bc;
            r_cur_bc     <= w_bc;
          end
        end
        S_DATA: begin
          if (rd_readdatavalid) begin
            // Index bit 8 guards against ever wrapping into entry 0.
            r_we         <= ~r_idx[8];
            r_waddr      <= r_idx[7:0];
            r_wdata      <= rd_readdata;
            r_idx        <= r_idx + 9'd1;
            r_burst_left <= r_burst_left - 8'd1;
            if (r_burst_left == 8'd1) begin
              r_addr <= r_addr + w_step;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rd_read       = (r_state == S_REQ);
  assign rd_addr       = r_addr;
  assign rd_burstcount = w_bc;
  assign wbuf_we       = r_we;
  assign wbuf_waddr    = r_waddr;
  assign wbuf_wdata    = r_wdata;
  assign wfetch_busy   = (r_state != S_IDLE);
  assign wfetch_done   = (r_state == S_DONE);

endmodule

`default_nettype wire

// File: doc/conv3d_wfetch.md
CONV3D_WFETCH -- requirements
Module: conv3d_wfetch

Interface
REQ-001 SHALL have parameter AW, default 30: memory byte-address width.
REQ-002 SHALL have parameter DW, default 256: read-data and weight-word width in bits (multiple of 8).
REQ-003 SHALL have parameter MAXBURST, default 16: maximum words per read burst (1..128).
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-low (rst=0 resets).
REQ-006 SHALL have port cfg_prefetch  input  1  single-cycle start pulse from the configuration stage.
REQ-007 SHALL have port cfg_waddr  input  AW  weight base byte address, DW/8-aligned.
REQ-008 SHALL have port cfg_length_w  input  8  weight length in DW words.
REQ-009 SHALL have port rd_read  output  1  read-request strobe (Avalon-MM style).
REQ-010 SHALL have port rd_addr  output  AW  burst start byte address.
REQ-011 SHALL have port rd_burstcount  output  8  words in the requested burst.
REQ-012 SHALL have port rd_waitrequest  input  1  slave stall; request held while high.
REQ-013 SHALL have port rd_readdatavalid  input  1  one returned word valid.
REQ-014 SHALL have port rd_readdata  input  DW  returned word.
REQ-015 SHALL have port wbuf_we  output  1  weight-buffer write enable.
REQ-016 SHALL have port wbuf_waddr  output  8  weight-buffer word index.
REQ-017 SHALL have port wbuf_wdata  output  DW  weight word to buffer.
REQ-018 SHALL have port wfetch_busy  output  1  high from accepted start until done.
REQ-019 SHALL have port wfetch_done  output  1  single-cycle completion pulse.

Function
REQ-020 SHALL implement FSM states IDLE, REQ, DATA, DONE.
REQ-021 In IDLE, when cfg_prefetch=1, SHALL latch cfg_waddr and cfg_length_w, clear word index to 0, and move to REQ if length>0, else to DONE.
REQ-022 SHALL ignore cfg_prefetch in every state other than IDLE; the latched parameters are not changed mid-transfer.
REQ-023 In REQ, SHALL drive rd_read=1, rd_addr=current address, rd_burstcount=min(remaining, MAXBURST), all held stable while rd_waitrequest=1.
REQ-024 SHALL treat the request as accepted on the cycle rd_read=1 and rd_waitrequest=0, then deassert rd_read and enter DATA.
REQ-025 SHALL keep at most one burst outstanding.
REQ-026 In DATA, on each rd_readdatavalid=1, SHALL on the next cycle assert wbuf_we=1 with wbuf_wdata=rd_readdata and wbuf_waddr=word index, then increment the index (one-cycle registered latency).
REQ-027 SHALL, after the last word of a burst, advance current address by burstcount*(DW/8) modulo 2^AW and go to REQ if remaining>0, else DONE.
REQ-028 SHALL ignore rd_readdatavalid outside DATA (no buffer write).
REQ-029 In DONE, SHALL assert wfetch_done=1 for exactly one cycle and return to IDLE; the final wbuf_we precedes or coincides with that pulse.
REQ-030 SHALL drive wfetch_busy=1 in REQ, DATA and DONE, 0 in IDLE.
REQ-031 SHALL keep remaining and word-index counters 9 bits wide so length 255 completes without overflow.

Reset
REQ-032 On rst=0, SHALL immediately force state IDLE and rd_read, wbuf_we, wfetch_busy, wfetch_done, rd_addr, rd_burstcount, wbuf_waddr, wbuf_wdata and all counters to 0.
REQ-033 SHALL abandon any transfer on reset mid-operation, without resuming it or pulsing done afterwards.

Verification
REQ-034 Start waddr=0x1000, length=40, MAXBURST=16, no stalls -> bursts (0x1000,16), (0x1200,16), (0x1400,8); wbuf_waddr 0..39 in order; one done pulse.
REQ-035 length=0 -> no rd_read; done pulse 2 cycles after start; busy high 1 cycle.
REQ-036 rd_waitrequest high for 5 cycles during the first request -> rd_addr/rd_burstcount stable all 5 cycles; exactly one request accepted.
REQ-037 Second cfg_prefetch mid-transfer with different address -> ignored; addresses and word count follow the first request.
REQ-038 rst low during second burst data -> all outputs 0 at once; after release, no done pulse and a new start of length 3 runs cleanly.
REQ-039 length=255, gapped readdatavalid -> 255 buffer writes, indices 0..254, last burst 15 words.
